// File: rtl/led_status_timer.sv
// led_status_timer: per-channel status LED driver (off / on / 1 Hz blink /
// activity stretch) sharing one prescaler, plus an optional uptime counter
// (sub-second cycle count, seconds, pulse-per-second strobe).
//
// Build option: define LED_STATUS_TIMER_UPTIME_EN to instantiate the seconds
// counter and pps register; when undefined, time_subsec, time_seconds and
// pps are tied to 0 while the prescaler and LEDs behave identically.
module led_status_timer #(
    parameter int unsigned CLK_FREQ_HZ    = 125000000,
    parameter int unsigned LED_COUNT      = 2,
    parameter int unsigned SEC_WIDTH      = 32,
    parameter int unsigned STRETCH_CYCLES = 6250000,
    parameter int unsigned LED_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*LED_COUNT-1:0] led_mode,
    input  logic [LED_COUNT-1:0]   act,
    output logic [LED_COUNT-1:0]   led,
    output logic [31:0]            time_subsec,
    output logic [SEC_WIDTH-1:0]   time_seconds,
    output logic                   pps
);

    localparam int unsigned STR_W = $clog2(STRETCH_CYCLES + 1);

    localparam logic [31:0]          DIV_LAST    = 32'(CLK_FREQ_HZ - 1);
    localparam logic [31:0]          DIV_HALF    = 32'(CLK_FREQ_HZ / 2 - 1);
    localparam logic [STR_W-1:0]     STRETCH_TOP = STR_W'(STRETCH_CYCLES);
    localparam logic [LED_COUNT-1:0] UNLIT       = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_ACT   = 2'b11
    } mode_e;

    logic [31:0]          r_div;
    logic                 r_ph;
    logic [STR_W-1:0]     r_stretch      [LED_COUNT];
    logic [STR_W-1:0]     w_stretch_next [LED_COUNT];
    logic [LED_COUNT-1:0] w_lit;
    logic [LED_COUNT-1:0] r_led;
    logic                 w_half_tick;
    logic                 w_sec_tick;

    assign w_sec_tick  = (r_div == DIV_LAST);
    assign w_half_tick = (r_div == DIV_HALF) || w_sec_tick;

    // Shared prescaler and the common blink phase derived from it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_div <= '0;
            r_ph  <= 1'b0;
        end else begin
            r_div <= w_sec_tick ? '0 : r_div + 32'd1;
            if (w_half_tick) begin
                r_ph <= ~r_ph;
            end
        end
    end

    // Next stretch value and per-channel lit state. Activity mode looks at
    // the next counter value so an act strobe lights the LED one cycle later
    // and a retrigger on the last count never drops the LED.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_lit = '0;
        for (int i = 0; i < int'(LED_COUNT); i++) begin
            w_stretch_next[i] = '0;
            if (act[i]) begin
                w_stretch_next[i] = STRETCH_TOP;
            end else if (r_stretch[i] != '0) begin
                w_stretch_next[i] = r_stretch[i] - STR_W'(1);
            end
            case (mode_e'(led_mode[2*i +: 2]))
                MODE_OFF:   w_lit[i] = 1'b0;
                MODE_ON:    w_lit[i] = 1'b1;
                MODE_BLINK: w_lit[i] = r_ph;
                MODE_ACT:   w_lit[i] = (w_stretch_next[i] != '0);
                default:    w_lit[i] = 1'b0;
            endcase
        end
    end

    // Stretch counters run in every mode; LED pins are registered with polarity applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LED_COUNT); i++) begin
                r_stretch[i] <= '0;
            end
            r_led <= UNLIT;
        end else begin
            for (int i = 0; i < int'(LED_COUNT); i++) begin
                r_stretch[i] <= w_stretch_next[i];
            end
            r_led <= w_lit ^ UNLIT;
        end
    end

    assign led = r_led;

`ifdef LED_STATUS_TIMER_UPTIME_EN
    logic [SEC_WIDTH-1:0] r_seconds;
    logic                 r_pps;

    // Seconds count and pps strobe, both aligned with the prescaler wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seconds <= '0;
            r_pps     <= 1'b0;
        end else begin
            r_pps <= w_sec_tick;
            if (w_sec_tick) begin
                r_seconds <= r_seconds + SEC_WIDTH'(1);
            end
        end
    end

    assign time_subsec  = r_div;
    assign time_seconds = r_seconds;
    assign pps          = r_pps;
`else
    assign time_subsec  = '0;
    assign time_seconds = '0;
    assign pps          = 1'b0;
`endif

endmodule

// File: tb/tb_led_status_timer.sv
// tb_led_status_timer: randomized and directed stimulus for led_status_timer,
// compared every cycle against an arithmetic model of elapsed cycles since
// reset release. Honours LED_STATUS_TIMER_UPTIME_EN for the uptime outputs.
module tb_led_status_timer;

    localparam int F   = 1000;
    localparam int LC  = 2;
    localparam int SW  = 4;
    localparam int STR = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    led_mode = '0;
    logic [1:0]    act = '0;
    logic [1:0]    led;
    logic [31:0]   time_subsec;
    logic [SW-1:0] time_seconds;
    logic          pps;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: edges since reset release and last edge that sampled act.
    int n = 0;
    int last_act [LC];

    led_status_timer #(
        .CLK_FREQ_HZ(F), .LED_COUNT(LC), .SEC_WIDTH(SW),
        .STRETCH_CYCLES(STR), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .led_mode(led_mode), .act(act), .led(led),
        .time_subsec(time_subsec), .time_seconds(time_seconds), .pps(pps)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", name, got, want, n, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic r, input logic [3:0] m, input logic [1:0] a);
        logic [1:0]  exp_led;
        logic [31:0] exp_sub;
        logic [31:0] exp_sec;
        logic        exp_pps;
        int          ph_prev;
        @(negedge clk);
        rst      = r;
        led_mode = m;
        act      = a;
        @(posedge clk);
        if (r) begin
            n = 0;
            for (int i = 0; i < LC; i++) last_act[i] = -1000000;
            exp_led = 2'b11;
            exp_sub = 0;
            exp_sec = 0;
            exp_pps = 1'b0;
        end else begin
            n++;
            for (int i = 0; i < LC; i++) if (a[i]) last_act[i] = n;
            // Phase flips every F/2 edges; the LED shows the phase held before this edge.
            ph_prev = ((n - 1) / (F / 2)) % 2;
            for (int i = 0; i < LC; i++) begin
                logic lit;
                case (m[2*i +: 2])
                    2'b00:   lit = 1'b0;
                    2'b01:   lit = 1'b1;
                    2'b10:   lit = (ph_prev == 1);
                    default: lit = (n - last_act[i] < STR);
                endcase
                exp_led[i] = ~lit;
            end
`ifdef LED_STATUS_TIMER_UPTIME_EN
            exp_sub = 32'(n % F);
            exp_sec = 32'((n / F) % (1 << SW));
            exp_pps = (n % F == 0);
`else
            exp_sub = 0;
            exp_sec = 0;
            exp_pps = 1'b0;
`endif
        end
        #1;
        check("led", 32'(led), 32'(exp_led));
        check("time_subsec", time_subsec, exp_sub);
        check("time_seconds", 32'(time_seconds), exp_sec);
        check("pps", 32'(pps), 32'(exp_pps));
    endtask

    initial begin
        logic [3:0] mode;
        logic [1:0] a;
        int pps_count;
        int last_pps;

        for (int i = 0; i < LC; i++) last_act[i] = -1000000;

        // Reset held 3 cycles, then pin the reset values directly.
        repeat (3) step(1'b1, 4'b1110, 2'b00);
        check("rst_led", 32'(led), 32'h3);
        check("rst_subsec", time_subsec, 32'h0);
        check("rst_seconds", 32'(time_seconds), 32'h0);
        check("rst_pps", 32'(pps), 32'h0);

        // Directed: ch0 blink, ch1 activity, then static modes on ch0.
        mode = 4'b1110;
        for (int k = 1; k <= 1600; k++) begin
            a = (k == 100 || k == 200 || k == 205) ? 2'b10 : 2'b00;
            if (k == 1050) mode[1:0] = 2'b00;
            if (k == 1060) mode[1:0] = 2'b01;
            if (k == 1070) mode[1:0] = 2'b10;
            step(1'b0, mode, a);
            case (k)
                100:  check("act_first_lit", 32'(led[1]), 32'h0);
                109:  check("act_last_lit", 32'(led[1]), 32'h0);
                110:  check("act_unlit", 32'(led[1]), 32'h1);
                214:  check("act_retrig_lit", 32'(led[1]), 32'h0);
                215:  check("act_retrig_unlit", 32'(led[1]), 32'h1);
                500:  check("blink_500", 32'(led[0]), 32'h1);
                501:  check("blink_501", 32'(led[0]), 32'h0);
                1000: check("blink_1000", 32'(led[0]), 32'h0);
                1001: check("blink_1001", 32'(led[0]), 32'h1);
                1051: check("mode_off", 32'(led[0]), 32'h1);
                1061: check("mode_on", 32'(led[0]), 32'h0);
                1071: check("mode_blink_back", 32'(led[0]), 32'h1);
                1501: check("blink_1501", 32'(led[0]), 32'h0);
                default: ;
            endcase
        end

        // Mid-operation reset at cycle 700 with activity in flight and blink lit.
        step(1'b1, 4'b1110, 2'b00);
        for (int k = 1; k < 700; k++) step(1'b0, 4'b1110, (k == 695) ? 2'b10 : 2'b00);
        check("pre_rst_led", 32'(led), 32'h0);
        step(1'b1, 4'b1110, 2'b10);
        check("mid_rst_led", 32'(led), 32'h3);
        check("mid_rst_subsec", time_subsec, 32'h0);
        check("mid_rst_seconds", 32'(time_seconds), 32'h0);
        check("mid_rst_pps", 32'(pps), 32'h0);

        // Random modes and activity across a full seconds-counter wrap.
        pps_count = 0;
        last_pps  = -1;
        mode      = 4'($urandom_range(0, 15));
        for (int k = 1; k <= 16 * F; k++) begin
            if ($urandom_range(0, 199) == 0) mode = 4'($urandom_range(0, 15));
            a[0] = ($urandom_range(0, 15) == 0);
            a[1] = ($urandom_range(0, 7) == 0);
            step(1'b0, mode, a);
            if (pps) begin
                pps_count++;
                if (last_pps >= 0) check("pps_spacing", 32'(k - last_pps), 32'(F));
                last_pps = k;
            end
        end
`ifdef LED_STATUS_TIMER_UPTIME_EN
        check("pps_count", 32'(pps_count), 32'd16);
`else
        check("pps_count", 32'(pps_count), 32'd0);
`endif
        check("seconds_wrapped", 32'(time_seconds), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_status_timer.md
# led_status_timer

Board status and uptime block for the FPGA top level, running on the 125 MHz core clock domain. It drives LED_COUNT status LEDs, each with its own runtime mode: off, on, 1 Hz blink, or activity-stretch. It also keeps a free-running uptime counter (seconds plus sub-second cycle count) with a one-cycle pulse-per-second strobe. It replaces hand-written per-LED blink counters and second counters at the top level with one parametrised, shared prescaler.

## Interface
Parameters:
- CLK_FREQ_HZ, default 125000000: clk frequency; must be even and ≥ 4.
- LED_COUNT, default 2: number of LED channels, 1–16.
- SEC_WIDTH, default 32: width of the seconds counter.
- STRETCH_CYCLES, default 6250000: activity on-time in clk cycles (50 ms at 125 MHz); ≥ 1.
- LED_ACTIVE_LOW, default 1: 1 means a lit LED drives 0.

Ports:
- clk, input, 1: core clock. One clock only.
- rst, input, 1: reset, synchronous, active-high.
- led_mode, input, 2*LED_COUNT: per-channel mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = on, 10 = blink 1 Hz, 11 = activity.
- act, input, LED_COUNT: per-channel activity strobe, level-sampled every cycle.
- led, output, LED_COUNT: LED pins, polarity per LED_ACTIVE_LOW.
- time_subsec, output, 32: cycle count within the current second, 0..CLK_FREQ_HZ-1.
- time_seconds, output, SEC_WIDTH: whole seconds since reset.
- pps, output, 1: one-cycle strobe at each second boundary.

## Operation
- **Prescaler** `div`, 32 bits:
  - Counts 0..CLK_FREQ_HZ-1, then wraps to 0.
  - half_tick is asserted when div == CLK_FREQ_HZ/2-1 or div == CLK_FREQ_HZ-1.
  - sec_tick is asserted when div == CLK_FREQ_HZ-1.
- **Blink phase** `ph`: a shared register that toggles on every half_tick. This gives a 50 % duty, 1 Hz square wave common to all channels, so blinking LEDs stay in phase with each other.
- **Per-channel lit state** (logical, before polarity):
  - Mode 00: lit = 0.
  - Mode 01: lit = 1.
  - Mode 10: lit = ph.
  - Mode 11: lit = (stretch_cnt[i] != 0).
- **Activity stretch counter**, one per channel, width clog2(STRETCH_CYCLES+1):
  - Loads STRETCH_CYCLES on any cycle where act[i] = 1. It retriggers while already counting.
  - Otherwise it decrements toward 0 and saturates at 0.
  - It runs in every mode, so switching into mode 11 immediately shows any activity still in progress.
- **Output polarity**: led[i] = lit[i] XOR LED_ACTIVE_LOW, registered.
- **Uptime**:
  - time_subsec mirrors div.
  - On sec_tick, time_seconds increments. It wraps from 2^SEC_WIDTH-1 to 0 with no flag.
  - pps is registered and asserted in the cycle after div == CLK_FREQ_HZ-1, which is the same cycle time_subsec reads 0 and time_seconds shows the new value.

## Timing
- **Reset values**, one cycle after rst is sampled high:
  - div = 0, ph = 0, all stretch counters = 0.
  - led = all unlit ({LED_COUNT{LED_ACTIVE_LOW}}).
  - time_subsec = 0, time_seconds = 0, pps = 0.
- **Reset mid-operation**: rst overrides all state, including an in-progress stretch or blink. Counting restarts from 0 on the first cycle after rst deasserts.
- **Latency**:
  - led_mode to led: 1 cycle.
  - act[i] rising to led[i] lit (mode 11): 1 cycle.
  - led stays lit for exactly STRETCH_CYCLES cycles after the last cycle in which act[i] = 1.
- **Blink**: the first ph rise occurs CLK_FREQ_HZ/2 cycles after reset release. A channel in mode 10 is therefore unlit for the first half second.
- **Simultaneous events**: act[i] = 1 in the same cycle the counter reaches 1 reloads the counter; the LED does not drop for a cycle.
- **Mode change**: does not reset ph or the stretch counter.

## Configuration
- Macro: LED_STATUS_TIMER_UPTIME_EN.
- **Defined**:
  - time_subsec, time_seconds and pps behave as described above.
- **Undefined**:
  - The seconds counter and pps register are not instantiated.
  - time_subsec, time_seconds and pps are tied to constant 0.
  - The prescaler and LED behaviour are unchanged.

## Test plan
Sim parameters: CLK_FREQ_HZ=1000, LED_COUNT=2, SEC_WIDTH=4, STRETCH_CYCLES=10, LED_ACTIVE_LOW=1.
- **Reset**: hold rst 3 cycles, then release → led=2'b11, time_seconds=0, time_subsec=0, pps=0. Assert rst again at cycle 700 → all outputs return to reset values the next cycle.
- **Blink**: mode 10 on channel 0.
  - led[0] = 1 for cycles 1–500 after release.
  - led[0] = 0 for cycles 501–1000.
  - Period is exactly 1000 cycles.
- **Activity**: mode 11 on channel 1, single act pulse at cycle T → led[1] = 0 for cycles T+1..T+10 and 1 at T+11. A second pulse at T+5 extends low through T+15.
- **Uptime wrap**: run 16000 cycles.
  - pps fires 16 times, each exactly 1000 cycles apart.
  - time_seconds goes 15→0 on the 16th pulse.
  - time_subsec = 0 in every pps cycle.
- **Static modes**: modes 00 and 01 → led = 1 and 0 respectively, within 1 cycle of a mode change. Toggling modes mid-blink does not shift ph alignment.
- **Macro undefined**: rebuild without the macro → time_seconds, time_subsec and pps stay 0 for 3000 cycles, while blink behaviour is identical to the macro-defined build.
